// File: rtl/wb_pkg.sv
// Shared constants for the MIPS write-back stage: source selects, load sizes, default width.
package wb_pkg;

  localparam int WB_DATA_W = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

endpackage

// File: rtl/load_extend.sv
// Combinational load-lane extraction (big-endian byte order) with sign/zero extension.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] ext_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 addresses the most significant byte of the aligned word.
  always_comb begin
    byte_lane = mem_data[DATA_W-1 -: 8];
    case (offset)
      2'd0: byte_lane = mem_data[DATA_W-1  -: 8];
      2'd1: byte_lane = mem_data[DATA_W-9  -: 8];
      2'd2: byte_lane = mem_data[DATA_W-17 -: 8];
      2'd3: byte_lane = mem_data[DATA_W-25 -: 8];
      default: byte_lane = mem_data[DATA_W-1 -: 8];
    endcase
  end

  assign half_lane = offset[1] ? mem_data[DATA_W-17 -: 16] : mem_data[DATA_W-1 -: 16];

  always_comb begin
    ext_data = mem_data;
    case (size)
      LD_BYTE: ext_data = {{(DATA_W-8){~is_unsigned & byte_lane[7]}}, byte_lane};
      LD_HALF: ext_data = {{(DATA_W-16){~is_unsigned & half_lane[15]}}, half_lane};
      default: ext_data = mem_data;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// MIPS write-back stage: source select, registered register-file write port,
// stall/flush handling and a retired-instruction counter.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_valid,
  output logic [CNT_W-1:0]      retired_cnt
);

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] next_data;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .mem_data    (mem_data),
    .offset      (alu_result[1:0]),
    .size        (load_size),
    .is_unsigned (load_unsigned),
    .ext_data    (load_data)
  );

  // Reserved select 11 falls through to the ALU result.
  always_comb begin
    next_data = alu_result;
    case (wb_sel)
      WB_SEL_MEM:  next_data = load_data;
      WB_SEL_LINK: next_data = pc_plus4;
      default:     next_data = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      retired_cnt <= '0;
    end else if (flush) begin
      // Squash only the control bits; rd/data keep their last values.
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
    end else if (!stall) begin
      wb_valid <= in_valid;
      wb_we    <= in_valid & reg_write & (rd != '0);
      wb_rd    <= rd;
      wb_data  <= next_data;
      if (in_valid) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Directed self-checking bench for write_back_stage (counter narrowed to 4 bits to reach wrap).
module tb_write_back_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          stall;
  logic          flush;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] pc_plus4;
  logic [1:0]    wb_sel;
  logic [1:0]    load_size;
  logic          load_unsigned;
  logic          reg_write;
  logic [AW-1:0] rd;
  logic          wb_we;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_valid;
  logic [CW-1:0] retired_cnt;

  int n_checks;
  int n_fail;
  int cnt_exp;

  write_back_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .alu_result    (alu_result),
    .mem_data      (mem_data),
    .pc_plus4      (pc_plus4),
    .wb_sel        (wb_sel),
    .load_size     (load_size),
    .load_unsigned (load_unsigned),
    .reg_write     (reg_write),
    .rd            (rd),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_valid      (wb_valid),
    .retired_cnt   (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check(tag, 32'(retired_cnt), 32'(cnt_exp & 15));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(wb_valid), 32'd0);
    check({tag, "_we"},    32'(wb_we),    32'd0);
    check({tag, "_rd"},    32'(wb_rd),    32'd0);
    check({tag, "_data"},  wb_data,       32'd0);
    check({tag, "_cnt"},   32'(retired_cnt), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cnt_exp  = 0;
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    alu_result = '0; mem_data = '0; pc_plus4 = '0; wb_sel = 2'b00;
    load_size = 2'b10; load_unsigned = 1'b0; reg_write = 1'b0; rd = '0;

    tick();
    check_zero("reset");
    rst = 1'b0;

    // ALU result
    alu_result = 32'd8; wb_sel = 2'b00; reg_write = 1'b1; rd = 5'd3; in_valid = 1'b1;
    tick(); cnt_exp++;
    check("alu_we",    32'(wb_we),    32'd1);
    check("alu_rd",    32'(wb_rd),    32'd3);
    check("alu_data",  wb_data,       32'd8);
    check("alu_valid", 32'(wb_valid), 32'd1);
    check_cnt("alu_cnt");

    // Byte loads
    wb_sel = 2'b01; mem_data = 32'h11F28000; alu_result = 32'h0000_0001;
    load_size = 2'b00; load_unsigned = 1'b0; rd = 5'd4;
    tick(); cnt_exp++;
    check("lb_signed", wb_data, 32'hFFFFFFF2);
    check("lb_rd", 32'(wb_rd), 32'd4);
    load_unsigned = 1'b1;
    tick(); cnt_exp++;
    check("lbu", wb_data, 32'h000000F2);
    alu_result = 32'h0000_0000; load_unsigned = 1'b0;
    tick(); cnt_exp++;
    check("lb_off0", wb_data, 32'h00000011);
    alu_result = 32'h0000_0002;
    tick(); cnt_exp++;
    check("lb_off2", wb_data, 32'hFFFFFF80);
    alu_result = 32'h0000_0003;
    tick(); cnt_exp++;
    check("lb_off3", wb_data, 32'h00000000);

    // Half and word loads
    mem_data = 32'h12348765; alu_result = 32'h0000_0002; load_size = 2'b01;
    tick(); cnt_exp++;
    check("lh_off2", wb_data, 32'hFFFF8765);
    alu_result = 32'h0000_0003; load_unsigned = 1'b1;
    tick(); cnt_exp++;
    check("lhu_off3", wb_data, 32'h00008765);
    alu_result = 32'h0000_0001; load_unsigned = 1'b0;
    tick(); cnt_exp++;
    check("lh_off1", wb_data, 32'h00001234);
    load_size = 2'b10;
    tick(); cnt_exp++;
    check("lw", wb_data, 32'h12348765);
    load_size = 2'b11;
    tick(); cnt_exp++;
    check("lw_size11", wb_data, 32'h12348765);

    // Extension only applies to the memory source
    wb_sel = 2'b00; alu_result = 32'h0000_0080; load_size = 2'b00;
    tick(); cnt_exp++;
    check("alu_noext", wb_data, 32'h00000080);

    // Link and reserved select
    wb_sel = 2'b10; pc_plus4 = 32'h0040001C;
    tick(); cnt_exp++;
    check("link", wb_data, 32'h0040001C);
    wb_sel = 2'b11; alu_result = 32'hCAFE0004;
    tick(); cnt_exp++;
    check("sel11_alu", wb_data, 32'hCAFE0004);
    check_cnt("sel11_cnt");

    // r0 write suppressed
    wb_sel = 2'b00; rd = 5'd0; reg_write = 1'b1; in_valid = 1'b1;
    tick(); cnt_exp++;
    check("r0_we",    32'(wb_we),    32'd0);
    check("r0_valid", 32'(wb_valid), 32'd1);
    check_cnt("r0_cnt");

    // No reg_write
    rd = 5'd9; reg_write = 1'b0;
    tick(); cnt_exp++;
    check("nowr_we", 32'(wb_we), 32'd0);
    check("nowr_valid", 32'(wb_valid), 32'd1);

    // Bubble
    in_valid = 1'b0; reg_write = 1'b1; rd = 5'd5;
    tick();
    check("bubble_we",    32'(wb_we),    32'd0);
    check("bubble_valid", 32'(wb_valid), 32'd0);
    check_cnt("bubble_cnt");

    // Stall then flush
    in_valid = 1'b1; alu_result = 32'd5; rd = 5'd7; reg_write = 1'b1;
    tick(); cnt_exp++;
    check("pre_stall_data", wb_data, 32'd5);
    stall = 1'b1; alu_result = 32'd9; rd = 5'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_data",  wb_data,       32'd5);
      check("stall_rd",    32'(wb_rd),    32'd7);
      check("stall_we",    32'(wb_we),    32'd1);
      check("stall_valid", 32'(wb_valid), 32'd1);
      check_cnt("stall_cnt");
    end
    stall = 1'b0; flush = 1'b1;
    tick();
    check("flush_valid", 32'(wb_valid), 32'd0);
    check("flush_we",    32'(wb_we),    32'd0);
    check("flush_data",  wb_data,       32'd5);
    check("flush_rd",    32'(wb_rd),    32'd7);
    check_cnt("flush_cnt");
    stall = 1'b1;
    tick();
    check("flush_over_stall_valid", 32'(wb_valid), 32'd0);
    check_cnt("flush_over_stall_cnt");
    flush = 1'b0; stall = 1'b0;

    // Reset mid-stall
    alu_result = 32'd6; rd = 5'd6;
    tick(); cnt_exp++;
    check("pre_rst_data", wb_data, 32'd6);
    check_cnt("pre_rst_cnt");
    stall = 1'b1; rst = 1'b1;
    tick(); cnt_exp = 0;
    check_zero("rst_stall");
    rst = 1'b0; stall = 1'b0;

    // Counter wrap at 16 retirements
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(); cnt_exp++;
    end
    check("cnt_15", 32'(retired_cnt), 32'd15);
    tick(); cnt_exp++;
    check("cnt_wrap", 32'(retired_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
